// File: rtl/bictr_decode_rx_pkg.sv
// bictr_decode_rx_pkg: shared state type and decoded-bus width helper
package bictr_decode_rx_pkg;
  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;
  function automatic int dec_w(int w);
    return 1 << w;
  endfunction
endpackage

// File: rtl/bictr_decode_rx_if.sv
// bictr_decode_rx_if: decoded count bus in, recovered count and flags out
interface bictr_decode_rx_if import bictr_decode_rx_pkg::*; #(parameter int width = 8);
  logic                    clr;
  logic                    valid;
  logic [dec_w(width)-1:0] count_dec;
  logic [width-1:0]        count;
  logic                    up_dn;
  logic                    step;
  logic                    locked;
  logic                    tercnt;
  logic                    err_onehot;
  logic                    err_jump;
  modport master (output clr, valid, count_dec,
                  input  count, up_dn, step, locked, tercnt, err_onehot, err_jump);
  modport slave  (input  clr, valid, count_dec,
                  output count, up_dn, step, locked, tercnt, err_onehot, err_jump);
endinterface

// File: rtl/bictr_decode_rx_onehot_enc_chk.sv
// onehot_enc_chk: OR-tree binary encoder plus zero/multi-hot detector
module onehot_enc_chk import bictr_decode_rx_pkg::*; #(parameter int width = 8) (
  input  logic [dec_w(width)-1:0] count_dec_i,
  output logic [width-1:0]        idx_o,
  output logic                    legal_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < dec_w(width); i++)
      for (int b = 0; b < width; b++)
        if (i[b]) idx_o[b] = idx_o[b] | count_dec_i[i];
  end
  // x & (x-1) clears the lowest set bit, so it is non-zero only for multi-hot
  assign legal_o = (|count_dec_i) && !(|(count_dec_i & (count_dec_i - 1'b1)));
endmodule

// File: rtl/bictr_decode_rx.sv
// bictr_decode_rx: one-hot count bus tracker with direction, step and error flags
module bictr_decode_rx import bictr_decode_rx_pkg::*; #(parameter int width = 8) (
  input logic clk,
  input logic reset,
  bictr_decode_rx_if.slave bus
);
  state_t           state_q, state_d;
  logic [width-1:0] count_q, count_d, idx, inc, dec;
  logic             up_dn_q, up_dn_d, step_q, step_d, tercnt_q, tercnt_d;
  logic             err_oh_q, err_oh_d, err_jump_q, err_jump_d, legal;
  onehot_enc_chk #(.width(width)) u_enc (
    .count_dec_i(bus.count_dec),
    .idx_o      (idx),
    .legal_o    (legal)
  );
  assign inc = count_q + 1'b1;
  assign dec = count_q - 1'b1;
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    up_dn_d    = up_dn_q;
    step_d     = 1'b0;
    err_oh_d   = 1'b0;
    err_jump_d = 1'b0;
    if (bus.clr) state_d = ST_UNLOCKED;
    else if (bus.valid && !legal) begin
      err_oh_d = 1'b1;
      state_d  = ST_UNLOCKED;
    end else if (bus.valid && state_q == ST_UNLOCKED) begin
      count_d = idx;
      state_d = ST_LOCKED;
    end else if (bus.valid && idx != count_q) begin
      count_d    = idx;
      step_d     = (idx == inc) || (idx == dec);
      up_dn_d    = (idx == inc) ? 1'b1 : (idx == dec) ? 1'b0 : up_dn_q;
      err_jump_d = !step_d;
    end
    tercnt_d = (state_d == ST_LOCKED) && (up_dn_d ? &count_d : ~|count_d);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_UNLOCKED;
      count_q    <= '0;
      up_dn_q    <= 1'b1;
      step_q     <= 1'b0;
      tercnt_q   <= 1'b0;
      err_oh_q   <= 1'b0;
      err_jump_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      up_dn_q    <= up_dn_d;
      step_q     <= step_d;
      tercnt_q   <= tercnt_d;
      err_oh_q   <= err_oh_d;
      err_jump_q <= err_jump_d;
    end
  end
  assign bus.count      = count_q;
  assign bus.up_dn      = up_dn_q;
  assign bus.step       = step_q;
  assign bus.locked     = (state_q == ST_LOCKED);
  assign bus.tercnt     = tercnt_q;
  assign bus.err_onehot = err_oh_q;
  assign bus.err_jump   = err_jump_q;
endmodule

// File: tb/tb_bictr_decode_rx.sv
// tb_bictr_decode_rx: directed and random checks against an arithmetic reference model
module tb_bictr_decode_rx;
  localparam int W = 3;
  localparam int N = 1 << W;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt, m_up, m_lock, m_step, m_eoh, m_ej;
  bictr_decode_rx_if #(.width(W)) bus ();
  bictr_decode_rx #(.width(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {bus.count, bus.up_dn, bus.step, bus.locked, bus.tercnt, bus.err_onehot, bus.err_jump};
  endfunction

  function automatic logic [8:0] expv();
    logic [2:0] c;
    int ter;
    c = m_cnt[2:0];
    ter = m_lock && (m_up ? (m_cnt == N - 1) : (m_cnt == 0));
    return {c, m_up[0], m_step[0], m_lock[0], ter[0], m_eoh[0], m_ej[0]};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_up = 1; m_lock = 0; m_step = 0; m_eoh = 0; m_ej = 0;
  endtask

  task automatic model_step(input logic c, input logic v, input logic [N-1:0] d);
    int idx, diff;
    m_step = 0; m_eoh = 0; m_ej = 0;
    if (c) m_lock = 0;
    else if (v) begin
      if ($countones(d) != 1) begin
        m_eoh = 1; m_lock = 0;
      end else begin
        idx = $clog2(d);
        if (!m_lock) m_lock = 1;
        else begin
          diff = (idx - m_cnt + N) % N;
          if (diff == 1) begin m_up = 1; m_step = 1; end
          else if (diff == N - 1) begin m_up = 0; m_step = 1; end
          else if (diff != 0) m_ej = 1;
        end
        m_cnt = idx;
      end
    end
  endtask

  task automatic apply(input logic c, input logic v, input logic [N-1:0] d);
    @(negedge clk);
    bus.clr = c; bus.valid = v; bus.count_dec = d;
    @(posedge clk);
    model_step(c, v, d);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.clr = 0; bus.valid = 0; bus.count_dec = '0;
    #12 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 8'h00);
      n_cmp++;
      if (obs() !== 9'b000_1_0_0_0_0_0) begin
        n_bad++; $display("FAIL reset_idle%0d got=%b want=%b", i, obs(), 9'b000_1_0_0_0_0_0);
      end
    end
  endtask

  task automatic test_up_steps();
    logic [N-1:0] seq [3] = '{8'h04, 8'h08, 8'h10};
    logic [8:0] want [3] = '{9'b010_1_0_1_0_0_0, 9'b011_1_1_1_0_0_0, 9'b100_1_1_1_0_0_0};
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, seq[i]);
      n_cmp++;
      if (obs() !== want[i] || obs() !== expv()) begin
        n_bad++; $display("FAIL up_step%0d got=%b want=%b model=%b", i, obs(), want[i], expv());
      end
    end
  endtask

  task automatic test_wrap();
    apply(0, 1, 8'h80);
    apply(0, 1, 8'h01);
    n_cmp++;
    if (obs() !== 9'b000_1_1_1_0_0_0) begin
      n_bad++; $display("FAIL wrap_up got=%b want=%b", obs(), 9'b000_1_1_1_0_0_0);
    end
    apply(0, 1, 8'h80);
    n_cmp++;
    if (obs() !== 9'b111_0_1_1_0_0_0) begin
      n_bad++; $display("FAIL wrap_down got=%b want=%b", obs(), 9'b111_0_1_1_0_0_0);
    end
  endtask

  task automatic test_tercnt();
    apply(0, 1, 8'h02);
    apply(0, 1, 8'h01);
    n_cmp++;
    if (obs() !== 9'b000_0_1_1_1_0_0 || obs() !== expv()) begin
      n_bad++; $display("FAIL tercnt_down got=%b want=%b", obs(), 9'b000_0_1_1_1_0_0);
    end
  endtask

  task automatic test_jump();
    apply(0, 1, 8'h01);
    apply(0, 1, 8'h20);
    n_cmp++;
    if (obs() !== expv() || bus.err_jump !== 1'b1 || bus.count !== 3'd5 || bus.locked !== 1'b1) begin
      n_bad++; $display("FAIL jump got=%b want=%b", obs(), expv());
    end
    apply(0, 1, 8'h20);
    n_cmp++;
    if (obs() !== expv() || bus.err_jump !== 1'b0) begin
      n_bad++; $display("FAIL jump_pulse got=%b want=%b", obs(), expv());
    end
  endtask

  task automatic test_onehot();
    logic [N-1:0] seq [4] = '{8'h08, 8'h00, 8'h0C, 8'h40};
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, seq[i]);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL onehot%0d got=%b want=%b", i, obs(), expv());
      end
    end
    n_cmp++;
    if (bus.count !== 3'd6 || bus.locked !== 1'b1 || bus.step !== 1'b0) begin
      n_bad++; $display("FAIL onehot_relock got=%b want count=6 locked=1 step=0", obs());
    end
  endtask

  task automatic test_clr();
    apply(0, 1, 8'h20);
    apply(1, 1, 8'h10);
    n_cmp++;
    if (obs() !== expv() || bus.locked !== 1'b0 || bus.count !== 3'd5) begin
      n_bad++; $display("FAIL clr got=%b want=%b", obs(), expv());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    int r, base;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      base = (m_cnt + $urandom_range(0, 2) + N - 1) % N;
      d = (r < 10) ? (8'h01 << base) : (r < 13) ? (8'h01 << $urandom_range(0, N - 1)) : 8'($urandom);
      apply($urandom_range(0, 19) == 0, $urandom_range(0, 5) != 0, d);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL random%0d in=%h got=%b want=%b", i, d, obs(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    apply(0, 1, 8'h80);
    apply(0, 1, 8'h40);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (obs() !== 9'b000_1_0_0_0_0_0) begin
      n_bad++; $display("FAIL async_reset got=%b want=%b", obs(), 9'b000_1_0_0_0_0_0);
    end
    bus.valid = 0;
    @(negedge clk) reset = 1'b1;
    apply(0, 1, 8'h08);
    n_cmp++;
    if (obs() !== 9'b011_1_0_1_0_0_0) begin
      n_bad++; $display("FAIL relock got=%b want=%b", obs(), 9'b011_1_0_1_0_0_0);
    end
  endtask

  initial begin
    test_reset();
    test_up_steps();
    test_wrap();
    test_tercnt();
    test_jump();
    test_onehot();
    test_clr();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
